exchange_scheduler: RTL and testbench

//  Sequences one replica-exchange round across all base slots of the exchange node chain.

---
 rtl/exchange_scheduler_pkg.sv | 57 +++++
 rtl/exchange_scheduler.sv | 170 +++++++++++++++++
 tb/tb_exchange_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/exchange_scheduler_pkg.sv
// Shared types and helpers for the replica-exchange scheduler.
// pair_cmd() is the single definition of the per-base command decode.
package exchange_scheduler_pkg;

    localparam int BASE_LOG  = 3;
    localparam int MAX_BASE  = 2 ** BASE_LOG;
    localparam int SCHED_GAP = 6;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_SELF = 2'd1,
        CMD_FOLW = 2'd2,
        CMD_PREV = 2'd3
    } exchange_command_t;

    typedef exchange_command_t ex_com_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Pair (k,k+1) swaps only when it belongs to this round's parity and exists.
    function automatic logic pair_active(input int k, input logic parity,
                                         input logic [MAX_BASE-1:0] swap,
                                         input int base_num);
        logic act;
        act = 1'b0;
        if ((k >= 0) && (k + 1 < base_num) && (k < MAX_BASE)) begin
            if (k[0] == parity) begin
                act = swap[k[BASE_LOG-1:0]];
            end else begin
                act = 1'b0;
            end
        end else begin
            act = 1'b0;
        end
        return act;
    endfunction

    function automatic exchange_command_t pair_cmd(input int base, input logic parity,
                                                   input logic [MAX_BASE-1:0] swap,
                                                   input int base_num);
        exchange_command_t cmd;
        if (pair_active(base, parity, swap, base_num)) begin
            cmd = CMD_FOLW;
        end else if (pair_active(base - 1, parity, swap, base_num)) begin
            cmd = CMD_PREV;
        end else begin
            cmd = CMD_SELF;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/exchange_scheduler.sv
// Walks all base slots of one replica-exchange round, issuing FOLW/PREV/SELF per base.
// Optional EXCHANGE_SKIP_SELF_EN: bases decoding to SELF get no slot at all.
module exchange_scheduler
    import exchange_scheduler_pkg::*;
#(
    parameter int BASE_NUM = 8,
    parameter int CITY_DIV = 4,
    parameter int GAP      = SCHED_GAP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                parity,
    input  logic [BASE_NUM-1:0] swap,
    output ex_com_t             command,
    output logic [BASE_LOG-1:0] ex_base_id_r,
    output logic [BASE_LOG-1:0] ex_base_id_w,
    output logic                busy,
    output logic                done
);

    localparam int SLOT  = CITY_DIV + GAP;
    localparam int CNT_W = (SLOT > 2) ? $clog2(SLOT) : 1;

    sched_state_t          state_q, state_d;
    logic [BASE_LOG-1:0]   base_q, base_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  parity_q;
    logic [MAX_BASE-1:0]   swap_q;
    ex_com_t               command_q, command_d;
    logic [BASE_LOG-1:0]   id_q, id_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  eff_parity_s;
    logic [MAX_BASE-1:0]   swap_ext_s;
    logic [MAX_BASE-1:0]   eff_swap_s;
    int                    search_from_s;
    int                    next_base_s;
    logic                  found_s;

    // On the accepting edge the live inputs decide; afterwards only the latched copy does.
    always_comb begin
        swap_ext_s                 = '0;
        swap_ext_s[BASE_NUM-1:0]   = swap;
        eff_parity_s  = (state_q == ST_IDLE) ? parity     : parity_q;
        eff_swap_s    = (state_q == ST_IDLE) ? swap_ext_s : swap_q;
        search_from_s = (state_q == ST_IDLE) ? 0 : int'(base_q) + 1;
    end

    // Next base to visit: lowest non-SELF base when skipping, else simply the following base.
    always_comb begin
        found_s     = 1'b0;
        next_base_s = 0;
`ifdef EXCHANGE_SKIP_SELF_EN
        for (int b = 0; b < BASE_NUM; b++) begin
            logic hit;
            hit = (b >= search_from_s) &&
                  (pair_cmd(b, eff_parity_s, eff_swap_s, BASE_NUM) != CMD_SELF);
            next_base_s = (hit && !found_s) ? b : next_base_s;
            found_s     = found_s | hit;
        end
`else
        found_s     = (search_from_s < BASE_NUM);
        next_base_s = search_from_s;
`endif
    end

    // State, counters and latched round parameters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            swap_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            if ((state_q == ST_IDLE) && start) begin
                parity_q <= parity;
                swap_q   <= swap_ext_s;
            end else begin
                parity_q <= parity_q;
                swap_q   <= swap_q;
            end
        end
    end

    // Next-state decode; WAIT counts SLOT-2 down to 0 so each base owns exactly SLOT cycles.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (found_s) begin
                        state_d = ST_ISSUE;
                        base_d  = next_base_s[BASE_LOG-1:0];
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(SLOT - 2);
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (found_s) begin
                        state_d = ST_ISSUE;
                        base_d  = next_base_s[BASE_LOG-1:0];
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a register.
    always_comb begin
        command_d = CMD_NOP;
        id_d      = id_q;
        if (state_d == ST_ISSUE) begin
            command_d = pair_cmd(int'(base_d), eff_parity_s, eff_swap_s, BASE_NUM);
            id_d      = base_d;
        end else begin
            command_d = CMD_NOP;
            id_d      = id_q;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            command_q <= CMD_NOP;
            id_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            command_q <= command_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign command      = command_q;
    assign ex_base_id_r = id_q;
    assign ex_base_id_w = id_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_exchange_scheduler.sv
// Directed bench for exchange_scheduler (BASE_NUM=4, CITY_DIV=4, GAP=4, SLOT=8).
// Expectations follow EXCHANGE_SKIP_SELF_EN when it is defined for the build.
module tb_exchange_scheduler;
    import exchange_scheduler_pkg::*;

    localparam int BN   = 4;
    localparam int CD   = 4;
    localparam int GP   = 4;
    localparam int SLOT = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                parity;
    logic [BN-1:0]       swap;
    ex_com_t             command;
    logic [BASE_LOG-1:0] ex_base_id_r;
    logic [BASE_LOG-1:0] ex_base_id_w;
    logic                busy;
    logic                done;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_id = 2'd0;

    always #5 clk = ~clk;

    exchange_scheduler #(.BASE_NUM(BN), .CITY_DIV(CD), .GAP(GP)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .parity       (parity),
        .swap         (swap),
        .command      (command),
        .ex_base_id_r (ex_base_id_r),
        .ex_base_id_w (ex_base_id_w),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int c, input logic [1:0] ec,
                              input logic eb, input logic ed);
        check($sformatf("%s cmd c%0d", tag, c),  32'(command),      32'(ec));
        check($sformatf("%s idr c%0d", tag, c),  32'(ex_base_id_r), 32'(exp_id));
        check($sformatf("%s idw c%0d", tag, c),  32'(ex_base_id_w), 32'(exp_id));
        check($sformatf("%s busy c%0d", tag, c), 32'(busy),         32'(eb));
        check($sformatf("%s done c%0d", tag, c), 32'(done),         32'(ed));
    endtask

    // bases/cmds pack the k-th issued slot at bits [2k+1:2k]; pa/pb are extra start
    // pulse cycles, tog the cycle in which swap is inverted (-1 = unused).
    task automatic run_round(input string tag, input logic par, input logic [3:0] sw,
                             input int n, input logic [7:0] bases, input logic [7:0] cmds,
                             input int pa, input int pb, input int tog);
        int done_at;
        done_at = 1 + SLOT * n;
        parity  = par;
        swap    = sw;
        start   = 1'b1;
        for (int c = 1; c <= done_at + 1; c++) begin
            int         k;
            logic [1:0] ec;
            tick();
            if (c == 1) start = 1'b0;
            k  = (c - 1) / SLOT;
            ec = CMD_NOP;
            if (((c - 1) % SLOT == 0) && (k < n)) begin
                ec     = cmds[2*k +: 2];
                exp_id = bases[2*k +: 2];
            end
            check_outs(tag, c, ec, (c <= done_at), (c == done_at));
            if ((c == pa + 1) || (c == pb + 1)) start = 1'b0;
            if ((c == pa) || (c == pb)) start = 1'b1;
            if (c == tog) swap = ~swap;
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        parity = 1'b0;
        swap   = 4'b0000;
        repeat (3) tick();
        exp_id = 2'd0;
        check_outs("reset", 0, CMD_NOP, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        run_round("p0_0101", 1'b0, 4'b0101, 4, 8'he4, 8'hee, -1, -1, -1);
`ifdef EXCHANGE_SKIP_SELF_EN
        run_round("p1_1111", 1'b1, 4'b1111, 2, 8'h09, 8'h0e, -1, -1, -1);
`else
        run_round("p1_1111", 1'b1, 4'b1111, 4, 8'he4, 8'h79, -1, -1, -1);
`endif
        run_round("busy_start", 1'b0, 4'b0101, 4, 8'he4, 8'hee, 5, 33, 10);
`ifdef EXCHANGE_SKIP_SELF_EN
        run_round("p0_0001", 1'b0, 4'b0001, 2, 8'h04, 8'h0e, -1, -1, -1);
        run_round("p0_0000", 1'b0, 4'b0000, 0, 8'h00, 8'h00, -1, -1, -1);
`else
        run_round("p0_0001", 1'b0, 4'b0001, 4, 8'he4, 8'h5e, -1, -1, -1);
        run_round("p0_0000", 1'b0, 4'b0000, 4, 8'he4, 8'h55, -1, -1, -1);
`endif

        // Mid-round reset: outputs clear, no done, then a fresh start is accepted.
        parity = 1'b0;
        swap   = 4'b0101;
        start  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            logic [1:0] ec;
            tick();
            if (c == 1) start = 1'b0;
            ec = CMD_NOP;
            if (c == 1) begin
                ec     = CMD_FOLW;
                exp_id = 2'd0;
            end
            if (c == 9) begin
                ec     = CMD_PREV;
                exp_id = 2'd1;
            end
            check_outs("pre_rst", c, ec, 1'b1, 1'b0);
        end
        reset = 1'b1;
        tick();
        exp_id = 2'd0;
        check_outs("mid_rst", 13, CMD_NOP, 1'b0, 1'b0);
        reset = 1'b0;
        for (int c = 14; c <= 20; c++) begin
            tick();
            check_outs("post_rst", c, CMD_NOP, 1'b0, 1'b0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("restart", 21, CMD_FOLW, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
